// File: rtl/spart_driver_ctrl_pkg.sv
// Shared constants, enums and the baud divisor function for the SPART bus-master controller.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [1:0] {
    BAUD_4800  = 2'b00,
    BAUD_9600  = 2'b01,
    BAUD_19200 = 2'b10,
    BAUD_38400 = 2'b11
  } baud_e;

  typedef enum logic [2:0] {
    PROG_LO,
    PROG_HI,
    IDLE,
    RX_RD,
    TX_WR,
    WAIT
  } state_e;

  // Each baud select doubles the rate, starting from 4800.
  function automatic logic [15:0] div_for(input int unsigned clk_hz, input baud_e sel);
    int unsigned baud;
    baud = 32'd4800 << sel;
    return 16'((clk_hz / (32'd16 * baud)) - 32'd1);
  endfunction

endpackage

// File: rtl/spart_driver_ctrl_if.sv
// Processor-side SPART control/handshake signals; the 8-bit tri-state databus stays a plain port.
interface spart_bus_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver_ctrl_echo_fifo.sv
// Echo FIFO, DEPTH x 8, wrapping pointers; the controller never pushes and pops in the same cycle.
module echo_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + AW'(1);
      count  <= count + CW'(1);
    end else if (pop) begin
      rd_ptr <= rd_ptr + AW'(1);
      count  <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/spart_driver_ctrl.sv
// SPART bus master: programs the baud divisor, then echoes received bytes back out through a FIFO.
//
// state   | meaning
// PROG_LO | write divisor low byte (ioaddr 10)
// PROG_HI | write divisor high byte (ioaddr 11), cfg_done set on exit
// IDLE    | bus released; cfg change, then rx/tx round-robin arbitration
// RX_RD   | read received byte, push to FIFO
// TX_WR   | write FIFO head to SPART, pop
// WAIT    | bus released one cycle so the SPART can drop rda/tbr
module spart_driver_ctrl
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int          DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             br_cfg,
  spart_bus_if.master            bus,
  inout  wire  [7:0]             databus,
  output logic                   cfg_done,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_e      state_q, state_nxt;
  logic        armed_q;
  logic        rr_last_q, rr_last_nxt;
  logic        cfg_done_q, cfg_done_nxt;
  logic        overflow_q, overflow_nxt;
  logic [1:0]  cfg_q, cfg_nxt;
  logic        push, pop;
  logic        rx_req, tx_req, full;
  logic [7:0]  head;
  logic [15:0] div_nxt;

  logic        iocs_q, iorw_q, drv_q;
  logic [1:0]  addr_q;
  logic [7:0]  dout_q;
  logic        iocs_d, iorw_d, drv_d;
  logic [1:0]  addr_d;
  logic [7:0]  dout_d;

  echo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (databus),
    .head  (head),
    .count (fifo_count)
  );

  assign full   = (fifo_count == FULL);
  assign rx_req = bus.rda && !full;
  assign tx_req = bus.tbr && (fifo_count != '0);

  // armed_q holds the FSM in PROG_LO for the first cycle after reset so
  // the bus is idle while reset is visible and PROG_LO is shown right after.
  always_comb begin
    state_nxt    = state_q;
    cfg_nxt      = cfg_q;
    rr_last_nxt  = rr_last_q;
    cfg_done_nxt = cfg_done_q;
    overflow_nxt = overflow_q;
    push         = 1'b0;
    pop          = 1'b0;
    if (!armed_q) begin
      state_nxt = PROG_LO;
    end else begin
      case (state_q)
        PROG_LO: state_nxt = PROG_HI;
        PROG_HI: begin
          state_nxt    = IDLE;
          cfg_done_nxt = 1'b1;
        end
        IDLE: begin
          if (br_cfg != cfg_q) begin
            cfg_nxt      = br_cfg;
            cfg_done_nxt = 1'b0;
            state_nxt    = PROG_LO;
          end else begin
            if (bus.rda && full) overflow_nxt = 1'b1;
            if (rx_req && tx_req) state_nxt = rr_last_q ? RX_RD : TX_WR;
            else if (rx_req)      state_nxt = RX_RD;
            else if (tx_req)      state_nxt = TX_WR;
          end
        end
        RX_RD: begin
          push        = 1'b1;
          rr_last_nxt = 1'b0;
          state_nxt   = WAIT;
        end
        TX_WR: begin
          pop         = 1'b1;
          rr_last_nxt = 1'b1;
          state_nxt   = WAIT;
        end
        WAIT:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bus outputs are decoded from the next state and registered.
  always_comb begin
    iocs_d  = 1'b0;
    iorw_d  = 1'b1;
    addr_d  = ADDR_DATA;
    drv_d   = 1'b0;
    dout_d  = '0;
    div_nxt = div_for(CLK_HZ, baud_e'(cfg_nxt));
    case (state_nxt)
      PROG_LO: begin
        iocs_d = 1'b1;
        iorw_d = 1'b0;
        addr_d = ADDR_DBL;
        drv_d  = 1'b1;
        dout_d = div_nxt[7:0];
      end
      PROG_HI: begin
        iocs_d = 1'b1;
        iorw_d = 1'b0;
        addr_d = ADDR_DBH;
        drv_d  = 1'b1;
        dout_d = div_nxt[15:8];
      end
      RX_RD: iocs_d = 1'b1;
      TX_WR: begin
        iocs_d = 1'b1;
        iorw_d = 1'b0;
        drv_d  = 1'b1;
        dout_d = head;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= PROG_LO;
      armed_q    <= 1'b0;
      cfg_q      <= br_cfg;
      rr_last_q  <= 1'b0;
      cfg_done_q <= 1'b0;
      overflow_q <= 1'b0;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      addr_q     <= ADDR_DATA;
      drv_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_nxt;
      armed_q    <= 1'b1;
      cfg_q      <= cfg_nxt;
      rr_last_q  <= rr_last_nxt;
      cfg_done_q <= cfg_done_nxt;
      overflow_q <= overflow_nxt;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      addr_q     <= addr_d;
      drv_q      <= drv_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = addr_q;
  assign databus    = drv_q ? dout_q : 8'hzz;
  assign cfg_done   = cfg_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_spart_driver_ctrl.sv
// Directed bench for spart_driver_ctrl with a minimal SPART data model on the databus.
module tb_spart_driver_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic [7:0] rx_byte = 8'h00;
  logic       probe_en = 1'b0;
  logic [7:0] probe_val = 8'hA5;
  wire  [7:0] databus;
  logic       cfg_done, overflow;
  logic [2:0] fifo_count;
  int         checks = 0;
  int         fails = 0;

  spart_bus_if bus();

  spart_driver_ctrl #(.CLK_HZ(50000000), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .bus        (bus),
    .databus    (databus),
    .cfg_done   (cfg_done),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  assign databus = probe_en ? probe_val : ((bus.iocs && bus.iorw) ? rx_byte : 8'hzz);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; br_cfg = 2'b01; bus.rda = 1'b0; bus.tbr = 1'b0; probe_en = 1'b1;
    tick(); tick();
    checks++; if (bus.iocs !== 1'b0) begin fails++; $display("FAIL rst_iocs got=%0b exp=0", bus.iocs); end
    checks++; if (bus.iorw !== 1'b1) begin fails++; $display("FAIL rst_iorw got=%0b exp=1", bus.iorw); end
    checks++; if (bus.ioaddr !== 2'b00) begin fails++; $display("FAIL rst_ioaddr got=%0b exp=00", bus.ioaddr); end
    checks++; if (databus !== 8'hA5) begin fails++; $display("FAIL rst_bus_released got=%h exp=a5", databus); end
    checks++; if ({cfg_done, overflow, fifo_count} !== 5'b0) begin fails++; $display("FAIL rst_status got=%b%b%0d exp=000", cfg_done, overflow, fifo_count); end
    probe_en = 1'b0; rst = 1'b1;
    tick();
    checks++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1010) begin fails++; $display("FAIL prog_lo_ctrl got=%b exp=1010", {bus.iocs, bus.iorw, bus.ioaddr}); end
    checks++; if (databus !== 8'h44) begin fails++; $display("FAIL prog_lo_data got=%h exp=44", databus); end
    tick();
    checks++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1011) begin fails++; $display("FAIL prog_hi_ctrl got=%b exp=1011", {bus.iocs, bus.iorw, bus.ioaddr}); end
    checks++; if (databus !== 8'h01) begin fails++; $display("FAIL prog_hi_data got=%h exp=01", databus); end
    checks++; if (cfg_done !== 1'b0) begin fails++; $display("FAIL prog_hi_cfg_done got=%b exp=0", cfg_done); end
    tick();
    checks++; if ({cfg_done, bus.iocs} !== 2'b10) begin fails++; $display("FAIL idle_after_prog got=%b exp=10", {cfg_done, bus.iocs}); end
  endtask

  task automatic test_echo();
    rx_byte = 8'h5A; bus.rda = 1'b1; bus.tbr = 1'b1;
    tick();
    checks++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1100) begin fails++; $display("FAIL echo_rd_ctrl got=%b exp=1100", {bus.iocs, bus.iorw, bus.ioaddr}); end
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL echo_cnt_before got=%0d exp=0", fifo_count); end
    bus.rda = 1'b0;
    tick();
    checks++; if ({bus.iocs, fifo_count} !== 4'b0001) begin fails++; $display("FAIL echo_wait got=%b exp=0001", {bus.iocs, fifo_count}); end
    tick();
    tick();
    checks++; if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b1000) begin fails++; $display("FAIL echo_wr_ctrl got=%b exp=1000", {bus.iocs, bus.iorw, bus.ioaddr}); end
    checks++; if (databus !== 8'h5A) begin fails++; $display("FAIL echo_wr_data got=%h exp=5a", databus); end
    bus.tbr = 1'b0;
    tick();
    checks++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL echo_cnt_after got=%0d exp=0", fifo_count); end
    tick();
  endtask

  task automatic test_overflow();
    logic any_cs;
    bus.tbr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rx_byte = 8'(i); bus.rda = 1'b1;
      tick();
      checks++; if (bus.iocs !== 1'b1 || bus.iorw !== 1'b1) begin fails++; $display("FAIL ovf_fill_rd%0d got=%b%b exp=11", i, bus.iocs, bus.iorw); end
      bus.rda = 1'b0;
      tick(); tick();
    end
    checks++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_full_cnt got=%0d exp=4", fifo_count); end
    rx_byte = 8'h05; bus.rda = 1'b1; any_cs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_cs = any_cs | bus.iocs;
    end
    bus.rda = 1'b0;
    checks++; if (any_cs !== 1'b0) begin fails++; $display("FAIL ovf_no_read got=%b exp=0", any_cs); end
    checks++; if ({overflow, fifo_count} !== 4'b1100) begin fails++; $display("FAIL ovf_flag got=%b/%0d exp=1/4", overflow, fifo_count); end
    bus.tbr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.iocs !== 1'b1 || bus.iorw !== 1'b0 || databus !== 8'(i)) begin fails++; $display("FAIL ovf_drain%0d got=%b%b/%h exp=10/%h", i, bus.iocs, bus.iorw, databus, 8'(i)); end
      tick(); tick();
    end
    bus.tbr = 1'b0;
    checks++; if ({overflow, fifo_count} !== 4'b1000) begin fails++; $display("FAIL ovf_drained got=%b/%0d exp=1/0", overflow, fifo_count); end
  endtask

  task automatic test_round_robin();
    logic [7:0] pre [2];
    logic       exp_rw [4];
    pre[0] = 8'hA1; pre[1] = 8'hA2;
    exp_rw[0] = 1'b0; exp_rw[1] = 1'b1; exp_rw[2] = 1'b0; exp_rw[3] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rx_byte = pre[i]; bus.rda = 1'b1;
      tick();
      bus.rda = 1'b0;
      tick(); tick();
    end
    checks++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL rr_preload got=%0d exp=2", fifo_count); end
    rx_byte = 8'hB0; bus.rda = 1'b1; bus.tbr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.iocs !== 1'b1 || bus.iorw !== exp_rw[i]) begin fails++; $display("FAIL rr_grant%0d got=%b%b exp=1%b", i, bus.iocs, bus.iorw, exp_rw[i]); end
      if (i == 0 || i == 2) begin
        checks++; if (databus !== pre[i/2]) begin fails++; $display("FAIL rr_wdata%0d got=%h exp=%h", i, databus, pre[i/2]); end
      end
      tick();
      if (i == 3) begin bus.rda = 1'b0; bus.tbr = 1'b0; end
      tick();
    end
    checks++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL rr_final_cnt got=%0d exp=2", fifo_count); end
  endtask

  task automatic test_cfg_change();
    bus.tbr = 1'b1;
    tick();
    checks++; if (bus.iorw !== 1'b0 || databus !== 8'hB0) begin fails++; $display("FAIL cfg_tx got=%b/%h exp=0/b0", bus.iorw, databus); end
    br_cfg = 2'b11; bus.tbr = 1'b0;
    tick();
    checks++; if ({bus.iocs, cfg_done, fifo_count} !== 5'b01001) begin fails++; $display("FAIL cfg_wait got=%b exp=01001", {bus.iocs, cfg_done, fifo_count}); end
    tick();
    tick();
    checks++; if ({bus.iocs, bus.iorw, bus.ioaddr, cfg_done} !== 5'b10100 || databus !== 8'h50) begin fails++; $display("FAIL cfg_prog_lo got=%b/%h exp=10100/50", {bus.iocs, bus.iorw, bus.ioaddr, cfg_done}, databus); end
    tick();
    checks++; if ({bus.iocs, bus.iorw, bus.ioaddr, cfg_done} !== 5'b10110 || databus !== 8'h00) begin fails++; $display("FAIL cfg_prog_hi got=%b/%h exp=10110/00", {bus.iocs, bus.iorw, bus.ioaddr, cfg_done}, databus); end
    tick();
    checks++; if ({bus.iocs, cfg_done, fifo_count} !== 5'b01001) begin fails++; $display("FAIL cfg_done_back got=%b exp=01001", {bus.iocs, cfg_done, fifo_count}); end
  endtask

  task automatic test_reset_mid();
    rx_byte = 8'h77; bus.rda = 1'b1;
    tick();
    bus.rda = 1'b0;
    tick(); tick();
    checks++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL mid_preload got=%0d exp=2", fifo_count); end
    br_cfg = 2'b00;
    tick();
    checks++; if (bus.ioaddr !== 2'b10 || databus !== 8'h8A) begin fails++; $display("FAIL mid_prog_lo got=%b/%h exp=10/8a", bus.ioaddr, databus); end
    tick();
    checks++; if (bus.ioaddr !== 2'b11 || databus !== 8'h02) begin fails++; $display("FAIL mid_prog_hi got=%b/%h exp=11/02", bus.ioaddr, databus); end
    rst = 1'b0; probe_en = 1'b1;
    tick();
    checks++; if ({bus.iocs, cfg_done, overflow, fifo_count} !== 6'b0) begin fails++; $display("FAIL mid_rst_state got=%b exp=000000", {bus.iocs, cfg_done, overflow, fifo_count}); end
    checks++; if (databus !== 8'hA5) begin fails++; $display("FAIL mid_rst_bus_released got=%h exp=a5", databus); end
    rst = 1'b1; probe_en = 1'b0;
    tick();
    checks++; if ({bus.iocs, bus.ioaddr} !== 3'b110 || databus !== 8'h8A) begin fails++; $display("FAIL mid_restart_lo got=%b/%h exp=110/8a", {bus.iocs, bus.ioaddr}, databus); end
    tick();
    checks++; if (databus !== 8'h02) begin fails++; $display("FAIL mid_restart_hi got=%h exp=02", databus); end
    tick();
    checks++; if ({cfg_done, bus.iocs} !== 2'b10) begin fails++; $display("FAIL mid_restart_done got=%b exp=10", {cfg_done, bus.iocs}); end
  endtask

  initial begin
    bus.rda = 1'b0;
    bus.tbr = 1'b0;
    test_reset();
    test_echo();
    test_overflow();
    test_round_robin();
    test_cfg_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spart_driver_ctrl.md
Name: spart_driver_ctrl

Overview:
- Bus-master controller that owns the SPART processor-side bus (iocs/iorw/ioaddr/databus).
- After reset it programs the baud divisor selected by br_cfg: low byte, then high byte.
- It then arbitrates the single bus between the receive path (SPART rda) and the transmit path (SPART tbr), echoing every received byte through a small internal FIFO.
- Sits between board switches/top level and the spart instance; it replaces a CPU for lab bring-up.

Parameters:
- CLK_HZ, 50000000, system clock frequency used to build the divisor table.
- DEPTH, 4, echo FIFO depth; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low: 0 = reset.
- br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- rda  input  1  SPART receive-data-available.
- tbr  input  1  SPART transmit-buffer-ready.
- iocs  output  1  SPART chip select.
- iorw  output  1  1 = read from SPART, 0 = write to SPART.
- ioaddr  output  2  00 = data, 01 = status (unused), 10 = divisor low byte, 11 = divisor high byte.
- databus  inout  8  driven only when iocs=1 and iorw=0; hi-Z otherwise.
- cfg_done  output  1  divisor programmed for the current br_cfg.
- fifo_count  output  log2(DEPTH)+1  bytes held in the echo FIFO.
- overflow  output  1  sticky: a byte was pending while the FIFO was full.

Behaviour:
- Reset is sampled on the clk edge when rst=0.
  - state = PROG_LO; FIFO pointers and count = 0.
  - iocs=0, iorw=1, ioaddr=00, databus hi-Z.
  - cfg_done=0, overflow=0, rr_last=0, cfg_latched=br_cfg.
- Divisor table: floor(CLK_HZ/(16*baud)) - 1, 16 bits, computed from CLK_HZ.
  - At 50 MHz: 4800→0x028A, 9600→0x0144, 19200→0x00A1, 38400→0x0050.
- Outputs iocs/iorw/ioaddr/databus are registered: each is a function of the current state only, with no combinational path from rda/tbr.
- State PROG_LO (1 cycle): iocs=1, iorw=0, ioaddr=10, databus=div[7:0]. Next state is PROG_HI.
- State PROG_HI (1 cycle): iocs=1, iorw=0, ioaddr=11, databus=div[15:8]. Next state is IDLE, and cfg_done is set to 1.
- State IDLE: iocs=0. Decision order:
  - If br_cfg != cfg_latched: latch br_cfg, clear cfg_done, go to PROG_LO. This takes precedence over rx/tx. The FIFO is preserved.
  - rx_req = rda & (count<DEPTH).
  - tx_req = tbr & (count>0).
  - If both are set: round-robin. Grant the side not granted last (rr_last: 0 = rx last, 1 = tx last).
  - Otherwise grant whichever request is set.
  - If rda=1 and count=DEPTH: set overflow. Do not read; the byte remains in the SPART.
- State RX_RD (1 cycle): iocs=1, iorw=1, ioaddr=00.
  - databus is captured at the end of the cycle and pushed to the FIFO; count+1.
  - rr_last=0. Next state is WAIT.
- State TX_WR (1 cycle): iocs=1, iorw=0, ioaddr=00, databus = FIFO head.
  - Pop at the end of the cycle; count-1. rr_last=1. Next state is WAIT.
- State WAIT (1 cycle): iocs=0. Lets the SPART drop rda/tbr. Next state is IDLE.
- Bus-op cadence: the minimum is 3 cycles per bus operation (IDLE→op→WAIT).
- FIFO rules:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Push and pop never occur in the same cycle (one bus op per cycle).
  - Count saturates at neither end because the grants are guarded.
- Reset mid-operation (any state, including PROG_HI or TX_WR): the next cycle shows reset values. The FIFO contents are discarded and the divisor is reprogrammed.
- br_cfg changes are ignored outside IDLE; they are acted on at the next IDLE cycle.
- overflow is cleared only by reset.

Decomposition:
- Package spart_pkg:
  - ioaddr constants ADDR_DATA=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11.
  - Baud enum and divisor function div_for(CLK_HZ, br_cfg).
  - FSM state enum {PROG_LO, PROG_HI, IDLE, RX_RD, TX_WR, WAIT}.
- Sub-module echo_fifo (DEPTH x 8, push/pop/count, synchronous active-low reset). The FSM plus arbiter stays in spart_driver_ctrl.

Test Plan:
- Reset with br_cfg=01, then release rst → cycle 1: iocs=1, iorw=0, ioaddr=10, databus=0x44. Cycle 2: ioaddr=11, databus=0x01. Cycle 3: cfg_done=1, iocs=0.
- rda pulses with SPART data 0x5A, tbr=1 → RX_RD reads 0x5A, then WAIT, IDLE. TX_WR drives databus=0x5A at ioaddr=00. fifo_count goes 0→1→0.
- tbr=0, four bytes 0x01..0x04 arrive, then a fifth rda → fifo_count=4, overflow=1, no fifth RX_RD. Raise tbr → writes occur in order 0x01, 0x02, 0x03, 0x04 (pointers wrap).
- rda and tbr held high with count=2 → grants alternate: TX, RX, TX, RX… starting opposite to rr_last. There is never a read and a write in the same cycle.
- br_cfg changes 01→11 while in TX_WR → the write completes, then WAIT, then PROG_LO/PROG_HI with 0x50/0x00. cfg_done drops for 2 cycles. FIFO count is unchanged.
- rst=0 asserted during PROG_HI with 2 bytes queued → the next cycle shows fifo_count=0, overflow=0, databus hi-Z. Release restarts at PROG_LO.
